spi_master_ctl: RTL and testbench

//   SPI master (initiator) for the spi_ctl bus bridge. It turns one host request
//   (read/write, 7-bit address, write data) into a 2-byte SPI frame on nss/sck/mosi.
//   It captures the miso byte returned during a read. It sits on the MCU/host side and

---
 rtl/spi_master_ctl_pkg.sv | 30 +++
 rtl/spi_master_ctl_tick_gen.sv | 30 +++
 rtl/spi_master_ctl.sv | 167 ++++++++++++++++
 tb/tb_spi_master_ctl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_ctl_pkg.sv
// Shared definitions for the SPI master: FSM states, frame layout constants
// and the helper that assembles the 16-bit frame from a host request.
package spi_master_ctl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    localparam int         FRAME_BITS = 16;
    localparam int         BYTE_BITS  = 8;
    localparam int         RW_BIT     = 7;
    localparam logic [7:0] READ_FILL  = 8'h00;

    // First byte carries rw at RW_BIT above the address; reads send a fill byte.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic       rw,
        input logic [6:0] addr,
        input logic [7:0] wdata
    );
        logic [BYTE_BITS-1:0] byte1;
        byte1         = {1'b0, addr};
        byte1[RW_BIT] = rw;
        return {byte1, (rw ? READ_FILL : wdata)};
    endfunction

endpackage

// File: rtl/spi_master_ctl_tick_gen.sv
// Clock divider for the SPI master: pulses tick once every CLK_DIV clk cycles,
// restarting from zero whenever clear is asserted.
module spi_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int              CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] div_cnt_reg;

    // With CLK_DIV=1 the counter sits at zero and tick is permanently high.
    assign tick = (div_cnt_reg == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_reg <= '0;
        end else if (clear || tick) begin
            div_cnt_reg <= '0;
        end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_ctl.sv
// SPI mode-0 master: sends one {rw, addr, data} 16-bit frame per host request
// and returns the second received byte of a read on rdata.
module spi_master_ctl
    import spi_master_ctl_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       nss,
    output logic       sck,
    output logic       mosi,
    input  logic       miso
);

    localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS);

    state_t state_reg;
    state_t state_next;

    logic                  tick;
    logic [FRAME_BITS-1:0] frame;
    // Bit 15 goes straight to mosi on load, so only the remaining 15 are held.
    logic [FRAME_BITS-2:0] tx_reg;
    logic [BYTE_BITS-1:0]  rx_reg;
    logic [4:0]            bit_cnt_reg;
    logic                  rw_reg;

    logic do_load;
    logic do_rise;
    logic do_fall;
    logic do_release;
    logic do_finish;

    assign frame = build_frame(rw, addr, wdata);

    spi_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .reset(reset),
        .clear(do_load),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (tick) begin
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (tick && sck && (bit_cnt_reg == LAST_BIT)) begin
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (tick) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Tick 1 (in SETUP) is the first rising edge; in SHIFT ticks alternate on sck level.
    always_comb begin
        do_load    = 1'b0;
        do_rise    = 1'b0;
        do_fall    = 1'b0;
        do_release = 1'b0;
        do_finish  = 1'b0;
        case (state_reg)
            ST_IDLE:  do_load    = start;
            ST_SETUP: do_rise    = tick;
            ST_SHIFT: begin
                do_rise = tick && !sck;
                do_fall = tick && sck;
            end
            ST_HOLD:  do_release = tick;
            ST_GAP:   do_finish  = tick;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nss         <= 1'b1;
            sck         <= 1'b0;
            mosi        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            rdata       <= 8'h00;
            tx_reg      <= '0;
            rx_reg      <= '0;
            bit_cnt_reg <= '0;
            rw_reg      <= 1'b0;
        end else begin
            done <= do_finish;

            if (do_load) begin
                tx_reg      <= frame[FRAME_BITS-2:0];
                rw_reg      <= frame[BYTE_BITS+RW_BIT];
                mosi        <= frame[FRAME_BITS-1];
                nss         <= 1'b0;
                busy        <= 1'b1;
                bit_cnt_reg <= '0;
            end

            if (do_rise) begin
                sck         <= 1'b1;
                rx_reg      <= {rx_reg[BYTE_BITS-2:0], miso};
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end

            if (do_fall) begin
                sck <= 1'b0;
                if (bit_cnt_reg == LAST_BIT) begin
                    mosi <= 1'b0;
                end else begin
                    mosi   <= tx_reg[FRAME_BITS-2];
                    tx_reg <= {tx_reg[FRAME_BITS-3:0], 1'b0};
                end
            end

            if (do_release) begin
                nss <= 1'b1;
            end

            // Writes leave the last read byte visible.
            if (do_finish) begin
                busy <= 1'b0;
                if (rw_reg) begin
                    rdata <= rx_reg;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_master_ctl.sv
// Directed + randomized bench for spi_master_ctl with an SPI slave/register model.
module tb_spi_master_ctl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       sel;

    logic       busy0, done0, nss0, sck0, mosi0;
    logic       busy1, done1, nss1, sck1, mosi1;
    logic [7:0] rdata0, rdata1;
    logic       miso = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wire start0 = start & ~sel;
    wire start1 = start & sel;

    spi_master_ctl #(.CLK_DIV(4)) dut4 (
        .clk(clk), .reset(reset), .start(start0), .rw(rw), .addr(addr), .wdata(wdata),
        .busy(busy0), .done(done0), .rdata(rdata0), .nss(nss0), .sck(sck0),
        .mosi(mosi0), .miso(miso)
    );

    spi_master_ctl #(.CLK_DIV(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .rw(rw), .addr(addr), .wdata(wdata),
        .busy(busy1), .done(done1), .rdata(rdata1), .nss(nss1), .sck(sck1),
        .mosi(mosi1), .miso(miso)
    );

    wire       busy_m  = sel ? busy1  : busy0;
    wire       done_m  = sel ? done1  : done0;
    wire       nss_m   = sel ? nss1   : nss0;
    wire       sck_m   = sel ? sck1   : sck0;
    wire       mosi_m  = sel ? mosi1  : mosi0;
    wire [7:0] rdata_m = sel ? rdata1 : rdata0;

    // Bus monitor and slave model (fixed-word mode or 128-byte register device).
    logic        slave_mode = 1'b0;
    logic [15:0] slave_word = 16'h0000;
    logic [7:0]  dev_regs [128];
    logic        sck_prev = 1'b0, nss_prev = 1'b1;
    int          rise_cnt = 0, nss_fall_cnt = 0, done_cnt = 0, nss_viol = 0;
    int          nss_high_run = 0, last_gap = 0, sl_idx = 0;
    logic [15:0] mosi_cap = 16'h0000;
    logic [15:0] sl_sh = 16'h0000;
    logic [15:0] sl_word = 16'h0000;

    always @(negedge clk) begin
        if (!nss_m && nss_prev) begin
            nss_fall_cnt++;
            last_gap = nss_high_run;
            sl_idx   = 0;
            sl_word  = slave_mode ? 16'h0000 : slave_word;
            miso     = sl_word[15];
        end
        if (nss_m) nss_high_run++;
        else       nss_high_run = 0;
        if (sck_m && !sck_prev) begin
            rise_cnt++;
            if (nss_m) nss_viol++;
            mosi_cap = {mosi_cap[14:0], mosi_m};
            sl_sh    = {sl_sh[14:0], mosi_m};
            sl_idx++;
        end
        if (!sck_m && sck_prev && !nss_m && sl_idx < 16) begin
            if (slave_mode && sl_idx == 8)
                sl_word[7:0] = sl_sh[7] ? dev_regs[sl_sh[6:0]] : 8'h00;
            miso = sl_word[15 - sl_idx];
        end
        if (nss_m && !nss_prev && slave_mode && sl_idx == 16 && !sl_sh[15])
            dev_regs[sl_sh[14:8]] = sl_sh[7:0];
        if (done_m) done_cnt++;
        sck_prev = sck_m;
        nss_prev = nss_m;
    end

    logic [7:0] exp_rdata [2];
    logic [7:0] exp_regs  [128];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete transaction; f_byte is the slave's returned byte (expected rdata on reads).
    task automatic do_frame(input logic f_rw, input logic [6:0] f_addr, input logic [7:0] f_wdata,
                            input logic [7:0] f_byte, input int inject);
        int          d = sel ? 1 : 4;
        int          r0, f0, dn0, v0, n;
        logic        seen;
        logic [15:0] exp_frame;
        exp_frame = {f_rw, f_addr, (f_rw ? 8'h00 : f_wdata)};
        @(negedge clk);
        slave_word = {8'h00, f_byte};
        r0 = rise_cnt; f0 = nss_fall_cnt; dn0 = done_cnt; v0 = nss_viol;
        start = 1'b1; rw = f_rw; addr = f_addr; wdata = f_wdata;
        @(posedge clk);
        #1 start = 1'b0;
        check("accept_nss", nss_m, 1'b0);
        check("accept_busy", busy_m, 1'b1);
        check("first_mosi", mosi_m, exp_frame[15]);
        n = 0; seen = 1'b0;
        while (n < 100 * d + 100) begin
            @(negedge clk);
            if (inject > 0 && n == inject) begin
                start = 1'b1; rw = ~rw; addr = ~addr; wdata = ~wdata;
            end else begin
                start = 1'b0;
            end
            if (done_m) begin
                seen = 1'b1;
                break;
            end
            n++;
        end
        start = 1'b0;
        check("done_seen", seen, 1'b1);
        check("done_latency", n, 34 * d);
        if (f_rw) exp_rdata[int'(sel)] = f_byte;
        check("rdata", rdata_m, exp_rdata[int'(sel)]);
        @(negedge clk);
        #1;
        check("done_width", done_m, 1'b0);
        check("busy_after", busy_m, 1'b0);
        check("nss_idle", nss_m, 1'b1);
        check("sck_idle", sck_m, 1'b0);
        check("rise_count", rise_cnt - r0, 16);
        check("nss_low_periods", nss_fall_cnt - f0, 1);
        check("done_pulses", done_cnt - dn0, 1);
        check("nss_high_at_rise", nss_viol - v0, 0);
        check("mosi_frame", mosi_cap, exp_frame);
        $display("txn div=%0d rw=%0d addr=%02h wdata=%02h mosi=%04h rdata=%02h done@%0d",
                 d, f_rw, f_addr, f_wdata, mosi_cap, rdata_m, n);
    endtask

    initial begin
        int          k, n, r0, f0, dn0;
        logic        sprev;
        logic [6:0]  a1, a2;
        logic [7:0]  b1, b2, v;
        logic [6:0]  waddr [4];

        reset = 1'b1; start = 1'b0; rw = 1'b0; addr = '0; wdata = '0; sel = 1'b0;
        exp_rdata[0] = 8'h00; exp_rdata[1] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_nss", {nss0, nss1}, 2'b11);
        check("rst_sck", {sck0, sck1}, 2'b00);
        check("rst_mosi", {mosi0, mosi1}, 2'b00);
        check("rst_busy", {busy0, busy1}, 2'b00);
        check("rst_done", {done0, done1}, 2'b00);
        check("rst_rdata", {rdata0, rdata1}, 16'h0000);
        @(negedge clk) reset = 1'b0;

        // Basic write and read frames
        do_frame(1'b0, 7'h01, 8'hF3, 8'h77, 0);
        do_frame(1'b1, 7'h05, 8'h00, 8'hAA, 0);
        // Start during an active frame is ignored
        do_frame(1'b0, 7'h2B, 8'hC4, 8'h00, 20);

        // Randomized frames at CLK_DIV=4
        for (int i = 0; i < 6; i++)
            do_frame(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), 0);

        // Reset at the 9th rising sck edge
        @(negedge clk);
        start = 1'b1; rw = 1'b0; addr = 7'h33; wdata = 8'($urandom);
        @(posedge clk);
        #1 start = 1'b0;
        k = 0; sprev = 1'b0; n = 0;
        while (k < 9 && n < 500) begin
            @(posedge clk);
            #1;
            if (sck_m && !sprev) k++;
            sprev = sck_m;
            n++;
        end
        check("reach_9th_rise", k, 9);
        reset = 1'b1;
        #1;
        check("abort_nss", nss_m, 1'b1);
        check("abort_sck", sck_m, 1'b0);
        check("abort_mosi", mosi_m, 1'b0);
        check("abort_busy", busy_m, 1'b0);
        @(negedge clk) reset = 1'b0;
        exp_rdata[0] = 8'h00; exp_rdata[1] = 8'h00;
        do_frame(1'b0, 7'h02, 8'h5A, 8'h00, 0);

        // Back-to-back reads at CLK_DIV=1 with start held high
        sel = 1'b1;
        do_frame(1'b1, 7'h11, 8'h00, 8'h3E, 0);
        a1 = 7'($urandom); a2 = 7'($urandom); b1 = 8'($urandom); b2 = 8'($urandom);
        @(negedge clk);
        slave_word = {8'h00, b1};
        r0 = rise_cnt; f0 = nss_fall_cnt; dn0 = done_cnt;
        start = 1'b1; rw = 1'b1; addr = a1;
        @(posedge clk);
        #1;
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (done_m) break;
            n++;
        end
        check("b2b_done1_latency", n, 34);
        check("b2b_rdata1", rdata_m, b1);
        check("b2b_mosi1", mosi_cap, {1'b1, a1, 8'h00});
        slave_word = {8'h00, b2}; addr = a2;
        @(posedge clk);
        #1 start = 1'b0;
        check("b2b_accept2", {busy_m, nss_m}, 2'b10);
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (done_m) break;
            n++;
        end
        check("b2b_done2_latency", n, 34);
        check("b2b_rdata2", rdata_m, b2);
        check("b2b_mosi2", mosi_cap, {1'b1, a2, 8'h00});
        @(negedge clk);
        #1;
        check("b2b_done_pulses", done_cnt - dn0, 2);
        check("b2b_nss_low_periods", nss_fall_cnt - f0, 2);
        check("b2b_rise_count", rise_cnt - r0, 32);
        check("b2b_gap_ok", (last_gap >= 1), 1'b1);
        $display("txn div=1 back-to-back reads %02h->%02h %02h->%02h gap=%0d", a1, rdata1, a2, b2, last_gap);
        exp_rdata[1] = b2;
        sel = 1'b0;

        // Register device: write then read back
        slave_mode = 1'b1;
        do_frame(1'b0, 7'h10, 8'h3C, 8'h00, 0);
        exp_regs[16] = 8'h3C;
        do_frame(1'b1, 7'h10, 8'h00, exp_regs[16], 0);
        for (int i = 0; i < 4; i++) begin
            waddr[i] = 7'(32 + 8 * i + $urandom_range(0, 7));
            v = 8'($urandom);
            do_frame(1'b0, waddr[i], v, 8'h00, 0);
            exp_regs[waddr[i]] = v;
        end
        for (int i = 3; i >= 0; i--)
            do_frame(1'b1, waddr[i], 8'($urandom), exp_regs[waddr[i]], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
